// File: rtl/n64_vi_gen_pkg.sv
// Shared definitions for the N64 VI bus: slot order, sync-word layout,
// test pattern codes and default 240p timing (also used by the receive side).
package n64_vi_gen_pkg;

  typedef enum logic [1:0] {
    SLOT_SYNC = 2'd0,
    SLOT_R    = 2'd1,
    SLOT_G    = 2'd2,
    SLOT_B    = 2'd3
  } slot_e;

  localparam int unsigned VSYNC_BIT = 3;
  localparam int unsigned CLAMP_BIT = 2;
  localparam int unsigned HSYNC_BIT = 1;
  localparam int unsigned CSYNC_BIT = 0;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_CHECKER = 2'd1,
    PAT_RAMP    = 2'd2,
    PAT_BLACK   = 2'd3
  } pattern_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned VI_COLOR_W     = 7;
  localparam int unsigned VI_H_TOTAL     = 773;
  localparam int unsigned VI_H_SYNC      = 57;
  localparam int unsigned VI_CLAMP_W     = 32;
  localparam int unsigned VI_H_ACT_START = 108;
  localparam int unsigned VI_H_ACT       = 640;
  localparam int unsigned VI_V_TOTAL     = 263;
  localparam int unsigned VI_V_SYNC      = 3;
  localparam int unsigned VI_V_ACT_START = 20;
  localparam int unsigned VI_V_ACT       = 240;

  // Slots always run sync, R, G, B and wrap.
  function automatic slot_e slot_next(input slot_e s);
    return slot_e'(s + 2'd1);
  endfunction

endpackage

// File: rtl/n64_vi_pattern.sv
// Combinational test pattern P(x,y) for one pixel; rgb[0]=R, rgb[1]=G, rgb[2]=B.
// Only the low COLOR_W bits of x matter to every pattern (COLOR_W >= 6).
module n64_vi_pattern
  import n64_vi_gen_pkg::*;
#(
  parameter int unsigned COLOR_W = VI_COLOR_W
) (
  input  pattern_e                  pat,
  input  logic [COLOR_W-1:0]        x,
  input  logic                      y_lsb,
  output logic [2:0][COLOR_W-1:0]   rgb
);

  always_comb begin
    rgb = '0;
    unique case (pat)
      PAT_BARS: begin
        rgb[0] = {COLOR_W{x[5]}};
        rgb[1] = {COLOR_W{x[4]}};
        rgb[2] = {COLOR_W{x[3]}};
      end
      PAT_CHECKER: begin
        if (x[0] ^ y_lsb) rgb = '1;
      end
      PAT_RAMP: begin
        rgb = {3{x}};
      end
      PAT_BLACK: begin
        rgb = '0;
      end
      default: begin
        rgb = '0;
      end
    endcase
  end

endmodule

// File: rtl/n64_vi_gen.sv
// N64 VI bus transmitter: 4-slot sync/R/G/B stream with programmable 240p
// timing, synthetic patterns and optional odd-pixel blur emulation.
module n64_vi_gen
  import n64_vi_gen_pkg::*;
#(
  parameter int unsigned COLOR_W     = VI_COLOR_W,
  parameter int unsigned H_TOTAL     = VI_H_TOTAL,
  parameter int unsigned H_SYNC      = VI_H_SYNC,
  parameter int unsigned CLAMP_W     = VI_CLAMP_W,
  parameter int unsigned H_ACT_START = VI_H_ACT_START,
  parameter int unsigned H_ACT       = VI_H_ACT,
  parameter int unsigned V_TOTAL     = VI_V_TOTAL,
  parameter int unsigned V_SYNC      = VI_V_SYNC,
  parameter int unsigned V_ACT_START = VI_V_ACT_START,
  parameter int unsigned V_ACT       = VI_V_ACT
) (
  input  logic               nCLK,
  input  logic               RST,
  input  logic               enable,
  input  logic               blur_en,
  input  logic [1:0]         pattern_sel,
  output logic               nDSYNC,
  output logic [COLOR_W-1:0] D_o,
  output logic               frame_start
);

  localparam int unsigned HW = $clog2(H_TOTAL + 1);
  localparam int unsigned VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_CLAMP_END = HW'(H_SYNC + CLAMP_W);
  localparam logic [HW-1:0] H_ACT_BEG   = HW'(H_ACT_START);
  localparam logic [HW-1:0] H_ACT_END   = HW'(H_ACT_START + H_ACT);
  localparam logic [HW-1:0] X_LAST      = HW'(H_ACT - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_BEG   = VW'(V_ACT_START);
  localparam logic [VW-1:0] V_ACT_END   = VW'(V_ACT_START + V_ACT);
  localparam logic          Y_FLIP      = 1'(V_ACT_START % 2);

  state_e        state, state_nxt;
  slot_e         slot, slot_nxt;
  logic [HW-1:0] h, h_nxt, h_adv;
  logic [VW-1:0] v, v_nxt, v_adv;
  logic          blur_q, blur_nxt;
  pattern_e      pat_q, pat_nxt;
  logic          line_end, frame_end;
  logic          emit, fs_nxt, nd_nxt;
  logic [COLOR_W-1:0] d_nxt;

  logic [HW-1:0]      x;
  logic [COLOR_W-1:0] xm, xc, xp;
  logic               y_lsb, active, odd_x, last_x;
  logic               hs_n, vs_n, cl_n;
  logic [2:0][COLOR_W-1:0] p_m, p_c, p_p, pix;
  logic [COLOR_W:0]   sum;

  // Raster position following the slot currently on the bus.
  always_comb begin
    line_end  = (slot == SLOT_B) && (h == H_LAST);
    frame_end = line_end && (v == V_LAST);
    h_adv     = h;
    v_adv     = v;
    if (slot == SLOT_B) h_adv = line_end ? '0 : h + HW'(1);
    if (line_end)       v_adv = frame_end ? '0 : v + VW'(1);
  end

  // Run control: start, frame-boundary relatch or stop.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    h_nxt     = h;
    v_nxt     = v;
    blur_nxt  = blur_q;
    pat_nxt   = pat_q;
    emit      = 1'b0;
    fs_nxt    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt = ST_RUN;
          slot_nxt  = SLOT_SYNC;
          h_nxt     = '0;
          v_nxt     = '0;
          blur_nxt  = blur_en;
          pat_nxt   = pattern_e'(pattern_sel);
          emit      = 1'b1;
          fs_nxt    = 1'b1;
        end
      end
      ST_RUN: begin
        slot_nxt = slot_next(slot);
        h_nxt    = h_adv;
        v_nxt    = v_adv;
        emit     = 1'b1;
        if (frame_end) begin
          if (!enable) begin
            state_nxt = ST_IDLE;
            emit      = 1'b0;
          end else begin
            blur_nxt = blur_en;
            pat_nxt  = pattern_e'(pattern_sel);
            fs_nxt   = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pixel coordinates and sync levels for the slot about to be emitted.
  always_comb begin
    x      = h_nxt - H_ACT_BEG;
    xc     = COLOR_W'(x);
    xm     = xc - COLOR_W'(1);
    xp     = xc + COLOR_W'(1);
    y_lsb  = v_nxt[0] ^ Y_FLIP;
    active = (h_nxt >= H_ACT_BEG) && (h_nxt < H_ACT_END) &&
             (v_nxt >= V_ACT_BEG) && (v_nxt < V_ACT_END);
    odd_x  = x[0];
    last_x = (x == X_LAST);
    hs_n   = !(h_nxt < H_SYNC_END);
    vs_n   = !(v_nxt < V_SYNC_END);
    cl_n   = !((h_nxt >= H_SYNC_END) && (h_nxt < H_CLAMP_END));
  end

  n64_vi_pattern #(.COLOR_W(COLOR_W)) u_pat_m (
    .pat   (pat_nxt),
    .x     (xm),
    .y_lsb (y_lsb),
    .rgb   (p_m)
  );

  n64_vi_pattern #(.COLOR_W(COLOR_W)) u_pat_c (
    .pat   (pat_nxt),
    .x     (xc),
    .y_lsb (y_lsb),
    .rgb   (p_c)
  );

  n64_vi_pattern #(.COLOR_W(COLOR_W)) u_pat_p (
    .pat   (pat_nxt),
    .x     (xp),
    .y_lsb (y_lsb),
    .rgb   (p_p)
  );

  // Blur: odd pixels average their neighbours; the last column has no right
  // neighbour, so the left one stands in for it.
  always_comb begin
    sum = '0;
    pix = '0;
    for (int c = 0; c < 3; c++) begin
      sum = {1'b0, p_m[c]} + {1'b0, (last_x ? p_m[c] : p_p[c])};
      if (!active)
        pix[c] = '0;
      else if (blur_nxt && odd_x)
        pix[c] = COLOR_W'(sum >> 1);
      else
        pix[c] = p_c[c];
    end
  end

  always_comb begin
    nd_nxt = 1'b1;
    d_nxt  = '0;
    if (emit) begin
      unique case (slot_nxt)
        SLOT_SYNC: begin
          nd_nxt           = 1'b0;
          d_nxt[VSYNC_BIT] = vs_n;
          d_nxt[CLAMP_BIT] = cl_n;
          d_nxt[HSYNC_BIT] = hs_n;
          d_nxt[CSYNC_BIT] = hs_n & vs_n;
        end
        SLOT_R:  d_nxt = pix[0];
        SLOT_G:  d_nxt = pix[1];
        SLOT_B:  d_nxt = pix[2];
        default: d_nxt = '0;
      endcase
    end
  end

  always_ff @(negedge nCLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      slot        <= SLOT_SYNC;
      h           <= '0;
      v           <= '0;
      blur_q      <= 1'b0;
      pat_q       <= PAT_BARS;
      nDSYNC      <= 1'b1;
      D_o         <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      slot        <= slot_nxt;
      h           <= h_nxt;
      v           <= v_nxt;
      blur_q      <= blur_nxt;
      pat_q       <= pat_nxt;
      nDSYNC      <= nd_nxt;
      D_o         <= d_nxt;
      frame_start <= fs_nxt;
    end
  end

endmodule

// File: tb/tb_n64_vi_gen.sv
// Bench for n64_vi_gen on a shrunken raster: spot-check table, corner-case
// sequences and a randomized run against a cycle-count based reference model.
module tb_n64_vi_gen;

  localparam int CW    = 7;
  localparam int HT    = 48;
  localparam int HS    = 5;
  localparam int CLW   = 3;
  localparam int HAS   = 12;
  localparam int HA    = 32;
  localparam int VT    = 10;
  localparam int VS    = 2;
  localparam int VAS   = 3;
  localparam int VA    = 5;
  localparam int FRAME = 4 * HT * VT;

  logic          nCLK = 1'b0;
  logic          RST  = 1'b1;
  logic          enable = 1'b0;
  logic          blur_en = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic          nDSYNC;
  logic [CW-1:0] D_o;
  logic          frame_start;

  int total = 0;
  int bad   = 0;

  always #5 nCLK = ~nCLK;

  n64_vi_gen #(
    .COLOR_W(CW), .H_TOTAL(HT), .H_SYNC(HS), .CLAMP_W(CLW),
    .H_ACT_START(HAS), .H_ACT(HA), .V_TOTAL(VT), .V_SYNC(VS),
    .V_ACT_START(VAS), .V_ACT(VA)
  ) dut (
    .nCLK        (nCLK),
    .RST         (RST),
    .enable      (enable),
    .blur_en     (blur_en),
    .pattern_sel (pattern_sel),
    .nDSYNC      (nDSYNC),
    .D_o         (D_o),
    .frame_start (frame_start)
  );

  // Reference: position is just the number of cycles since the frame began.
  bit         m_run  = 1'b0;
  int         mk     = 0;
  logic [1:0] m_pat  = 2'd0;
  bit         m_blur = 1'b0;

  always @(negedge nCLK or posedge RST) begin
    if (RST) begin
      m_run = 1'b0;
      mk    = 0;
    end else if (!m_run) begin
      if (enable) begin
        m_run  = 1'b1;
        mk     = 0;
        m_pat  = pattern_sel;
        m_blur = blur_en;
      end
    end else begin
      mk = (mk + 1) % FRAME;
      if (mk == 0) begin
        if (!enable) m_run = 1'b0;
        else begin
          m_pat  = pattern_sel;
          m_blur = blur_en;
        end
      end
    end
  end

  function automatic int pat_c(input logic [1:0] p, input int x, input int y, input int c);
    int b;
    case (p)
      2'd0: begin
        b = (x / 8) % 8;
        return ((b >> (2 - c)) % 2 == 1) ? 127 : 0;
      end
      2'd1: return ((x + y) % 2 == 1) ? 127 : 0;
      2'd2: return x % 128;
      default: return 0;
    endcase
  endfunction

  function automatic int pix_c(input logic [1:0] p, input bit blur, input int x, input int y, input int c);
    int l, r;
    if (blur && (x % 2 == 1)) begin
      l = pat_c(p, x - 1, y, c);
      r = (x == HA - 1) ? l : pat_c(p, x + 1, y, c);
      return (l + r) / 2;
    end
    return pat_c(p, x, y, c);
  endfunction

  // Expected {frame_start, nDSYNC, D_o}.
  function automatic logic [8:0] exp_out(input bit run, input int k, input logic [1:0] p, input bit blur);
    int s, n, h, v, x, y;
    bit hs_n, vs_n, cl_n;
    logic [6:0] d;
    if (!run) return {1'b0, 1'b1, 7'd0};
    s = k % 4;
    n = k / 4;
    h = n % HT;
    v = n / HT;
    if (s == 0) begin
      hs_n = (h >= HS);
      vs_n = (v >= VS);
      cl_n = !((h >= HS) && (h < HS + CLW));
      d = {3'b000, vs_n, cl_n, hs_n, hs_n & vs_n};
      return {(k == 0), 1'b0, d};
    end
    x = h - HAS;
    y = v - VAS;
    if (x < 0 || x >= HA || y < 0 || y >= VA) d = 7'd0;
    else d = 7'(pix_c(p, blur, x, y, s - 1));
    return {1'b0, 1'b1, d};
  endfunction

  function automatic int kpos(input int h, input int v, input int s);
    return ((v * HT) + h) * 4 + s;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge nCLK);
    check("scoreboard", 32'({frame_start, nDSYNC, D_o}), 32'(exp_out(m_run, mk, m_pat, m_blur)));
  endtask

  task automatic wait_pos(input int target, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < FRAME + 16 && !hit; i++) begin
      tick();
      hit = m_run && (mk == target);
    end
    if (!hit) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic rst_pulse();
    enable = 1'b0;
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    tick();
  endtask

  typedef struct {
    int         h;
    int         v;
    int         s;
    logic [1:0] p;
    bit         b;
    logic [6:0] e;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int h, input int v, input int s,
                              input logic [1:0] p, input bit b, input logic [6:0] e);
    vec_t t;
    t.h = h; t.v = v; t.s = s; t.p = p; t.b = b; t.e = e;
    vecs.push_back(t);
  endfunction

  initial begin
    int n_sync, n_h, n_c, n_v;

    // sync words (h, v, slot 0)
    add(0, 0, 0, 2'd0, 1'b0, 7'h04);
    add(5, 0, 0, 2'd0, 1'b0, 7'h02);
    add(8, 0, 0, 2'd0, 1'b0, 7'h06);
    add(20, 5, 0, 2'd0, 1'b0, 7'h0F);
    add(2, 4, 0, 2'd0, 1'b0, 7'h0C);
    // bars, no blur
    add(HAS + 0,  VAS, 3, 2'd0, 1'b0, 7'h00);
    add(HAS + 8,  VAS, 3, 2'd0, 1'b0, 7'h7F);
    add(HAS + 8,  VAS, 1, 2'd0, 1'b0, 7'h00);
    add(HAS + 16, VAS, 2, 2'd0, 1'b0, 7'h7F);
    add(HAS + 31, VAS + 1, 1, 2'd0, 1'b0, 7'h00);
    // bars, blur
    add(HAS + 7,  VAS, 3, 2'd0, 1'b1, 7'h3F);
    add(HAS + 7,  VAS, 1, 2'd0, 1'b1, 7'h00);
    add(HAS + 6,  VAS, 3, 2'd0, 1'b1, 7'h00);
    add(HAS + 8,  VAS, 3, 2'd0, 1'b1, 7'h7F);
    add(HAS + 31, VAS, 3, 2'd0, 1'b1, 7'h7F);
    // checker
    add(HAS + 3, VAS,     1, 2'd1, 1'b1, 7'h00);
    add(HAS + 5, VAS + 1, 2, 2'd1, 1'b1, 7'h7F);
    add(HAS + 3, VAS,     1, 2'd1, 1'b0, 7'h7F);
    // ramp, black, outside active region
    add(HAS + 13, VAS, 1, 2'd2, 1'b0, 7'h0D);
    add(HAS + 13, VAS, 2, 2'd2, 1'b1, 7'h0D);
    add(HAS + 31, VAS, 3, 2'd2, 1'b1, 7'h1E);
    add(HAS + 31, VAS, 3, 2'd2, 1'b0, 7'h1F);
    add(HAS + 5,  VAS, 3, 2'd3, 1'b0, 7'h00);
    add(HAS - 1,  VAS, 1, 2'd2, 1'b0, 7'h00);
    add(HAS + HA, VAS, 1, 2'd2, 1'b0, 7'h00);
    add(HAS + 8,  VAS + VA, 1, 2'd2, 1'b0, 7'h00);
    add(HAS + 8,  VAS + VA - 1, 1, 2'd2, 1'b0, 7'h08);

    // Reset state
    repeat (3) @(posedge nCLK);
    check("reset_ndsync", 32'(nDSYNC), 1);
    check("reset_d", 32'(D_o), 0);
    check("reset_fs", 32'(frame_start), 0);
    RST = 1'b0;
    tick();
    tick();
    check("idle_hold_ndsync", 32'(nDSYNC), 1);

    // First edge with enable, then one full line of sync-word counts
    enable = 1'b1;
    tick();
    check("start_ndsync", 32'(nDSYNC), 0);
    check("start_d", 32'(D_o), 32'h04);
    check("start_fs", 32'(frame_start), 1);
    n_sync = 0; n_h = 0; n_c = 0; n_v = 0;
    for (int i = 0; i < 4 * HT; i++) begin
      if (i > 0) tick();
      if (!nDSYNC) begin
        n_sync++;
        if (!D_o[1]) n_h++;
        if (!D_o[2]) n_c++;
        if (!D_o[3]) n_v++;
      end
    end
    check("line_sync_words", n_sync, HT);
    check("line_hsync_low", n_h, HS);
    check("line_clamp_low", n_c, CLW);
    check("line_vsync_low", n_v, HT);

    // Spot-check table
    for (int i = 0; i < vecs.size(); i++) begin
      rst_pulse();
      pattern_sel = vecs[i].p;
      blur_en     = vecs[i].b;
      enable      = 1'b1;
      wait_pos(kpos(vecs[i].h, vecs[i].v, vecs[i].s), $sformatf("vec%0d", i));
      check($sformatf("vec%0d", i), 32'(D_o), 32'(vecs[i].e));
    end

    // Settings change and enable drop mid-frame
    rst_pulse();
    pattern_sel = 2'd0;
    blur_en     = 1'b0;
    enable      = 1'b1;
    wait_pos(kpos(0, 4, 0), "drop_mid");
    pattern_sel = 2'd2;
    blur_en     = 1'b1;
    enable      = 1'b0;
    wait_pos(kpos(HAS + 7, 5, 3), "drop_keep");
    check("drop_frame_unchanged", 32'(D_o), 0);
    wait_pos(FRAME - 4, "drop_last");
    check("drop_last_sync", 32'(nDSYNC), 0);
    repeat (4) tick();
    check("drop_idle_ndsync", 32'(nDSYNC), 1);
    check("drop_idle_d", 32'(D_o), 0);
    check("drop_idle_fs", 32'(frame_start), 0);
    repeat (8) tick();
    check("drop_stays_idle", 32'(nDSYNC), 1);
    enable = 1'b1;
    tick();
    check("restart_fs", 32'(frame_start), 1);

    // Asynchronous reset in the middle of a line
    rst_pulse();
    enable = 1'b1;
    wait_pos(kpos(20, 4, 0), "async");
    check("async_pre_sync", 32'(nDSYNC), 0);
    #2 RST = 1'b1;
    #1;
    check("async_ndsync", 32'(nDSYNC), 1);
    check("async_d", 32'(D_o), 0);
    check("async_fs", 32'(frame_start), 0);
    tick();
    tick();
    RST = 1'b0;
    tick();
    check("async_restart_fs", 32'(frame_start), 1);
    check("async_restart_d", 32'(D_o), 32'h04);

    // Randomized settings and enable against the model
    rst_pulse();
    enable = 1'b1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      tick();
      if ($urandom_range(0, 63) == 0) pattern_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) blur_en = 1'($urandom_range(0, 1));
      if (i % 300 == 0) enable = ($urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
